crc_serial_param: RTL
=====================

CRC_SERIAL_PARAM -- requirements
Module: crc_serial_param

Interface
REQ-001 The block SHALL have parameter CRC_W, default 16, meaning CRC width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter POLY, default 16'h8005, meaning the generator polynomial in normal form with the x^CRC_W term omitted.
REQ-003 The block SHALL have parameter INIT, default all-zeros, meaning the register value loaded on start.
REQ-004 The block SHALL have parameter XOROUT, default all-zeros, meaning the value XORed into the final CRC before output.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 start  in  1  begins a frame; sampled in IDLE only.
REQ-008 abort  in  1  synchronous frame cancel.
REQ-009 din  in  1  message bit, MSB-first.
REQ-010 din_valid  in  1  din is valid this cycle.
REQ-011 din_last  in  1  qualifies the final message bit; sampled only with din_valid.
REQ-012 din_ready  out  1  block accepts din; equals (state==COMPUTE), combinational.
REQ-013 dout  out  1  registered code-word bit.
REQ-014 dout_valid  out  1  dout carries a code-word bit this cycle.
REQ-015 done  out  1  one-cycle pulse coincident with the last CRC bit on dout.
REQ-016 busy  out  1  high in COMPUTE and FLUSH.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, COMPUTE and FLUSH.
REQ-018 IDLE: crc_reg SHALL be loaded with INIT every cycle; start=1 moves the FSM to COMPUTE; din_valid is ignored in IDLE, including in the cycle start is asserted.
REQ-019 COMPUTE: a bit SHALL be accepted when din_valid=1; fb = crc_reg[CRC_W-1]^din; crc_reg <= {crc_reg[CRC_W-2:0],0} ^ (fb ? POLY : 0).
REQ-020 Each accepted bit SHALL appear on dout with dout_valid=1 exactly one cycle after acceptance; dout_valid=0 in cycles following non-acceptance.
REQ-021 Acceptance with din_last=1 SHALL move the FSM to FLUSH, load shift register sh with (next crc_reg value)^XOROUT, and clear bit counter cnt (width $clog2(CRC_W+1)).
REQ-022 FLUSH: each cycle dout <= sh[CRC_W-1], dout_valid <= 1, sh shifts left by one filling 0, cnt increments; din_ready=0.
REQ-023 When the bit output is the CRC_W-th bit (cnt==CRC_W-1), done <= 1 in the same edge and the FSM returns to IDLE.
REQ-024 The output stream SHALL be gap-free from last message bit to first CRC bit; total FLUSH length is exactly CRC_W cycles.
REQ-025 A frame SHALL contain at least one message bit; COMPUTE is left only by din_last or abort, with no timeout.
REQ-026 start SHALL be ignored in COMPUTE and FLUSH.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge with dout_valid=0 and done=0; abort takes priority over din_valid, din_last and FLUSH completion.
REQ-028 done and dout_valid SHALL never be asserted outside the cycles defined above.

Reset
REQ-029 rst=1 SHALL asynchronously force state=IDLE, crc_reg=INIT, sh=0, cnt=0, dout=0, dout_valid=0 and done=0, from any state including mid-FLUSH.
REQ-030 After rst deasserts, the block SHALL wait in IDLE for start; no output activity is permitted before then.

Verification
REQ-031 Defaults; start; ASCII "123456789" (72 bits, MSB-first, contiguous, din_last on bit 72) -> 72 echoed data bits, then 16 CRC bits = 16'hFEE8, done on the 88th dout_valid cycle.
REQ-032 CRC_W=8, POLY=8'h07; same message -> trailing CRC byte 8'hF4, FLUSH lasts 8 cycles.
REQ-033 Defaults; single bit din=1 with din_last -> CRC 16'h8005; with XOROUT=16'hFFFF -> 16'h7FFA.
REQ-034 Defaults; message with din_valid toggling 1/0 every cycle -> CRC identical to REQ-031, dout_valid gaps mirroring the input gaps, start pulses during COMPUTE have no effect.
REQ-035 Assert rst during the 5th FLUSH cycle -> outputs zero immediately, no done; a new frame after release yields correct CRC 16'hFEE8.
REQ-036 Assert abort mid-COMPUTE, then send a new frame -> abort-cycle state is IDLE; new frame CRC is unaffected by the aborted bits.

Source files
------------

// File: rtl/crc_serial_param.sv
// Bit-serial CRC generator: echoes message bits MSB-first, then appends the CRC_W-bit CRC.
// Three-state FSM (IDLE, COMPUTE, FLUSH) with a registered output stream and a done pulse.
module crc_serial_param #(
  parameter int unsigned       CRC_W  = 16,
  parameter logic [CRC_W-1:0]  POLY   = 16'h8005,
  parameter logic [CRC_W-1:0]  INIT   = '0,
  parameter logic [CRC_W-1:0]  XOROUT = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic din,
  input  logic din_valid,
  input  logic din_last,
  output logic din_ready,
  output logic dout,
  output logic dout_valid,
  output logic done,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(CRC_W + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

  logic [1:0]       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             done_q, done_d;

  logic             fb;
  logic [CRC_W-1:0] crc_step;

  // One LFSR step for the incoming bit; only committed when the bit is accepted.
  assign fb       = crc_q[CRC_W-1] ^ din;
  assign crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        crc_d = INIT;
        if (start && !abort) begin
          state_d = COMPUTE;
        end
      end

      COMPUTE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (din_valid) begin
          crc_d        = crc_step;
          dout_d       = din;
          dout_valid_d = 1'b1;
          if (din_last) begin
            state_d = FLUSH;
            sh_d    = crc_step ^ XOROUT;
            cnt_d   = '0;
          end
        end
      end

      FLUSH: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          dout_d       = sh_q[CRC_W-1];
          dout_valid_d = 1'b1;
          sh_d         = {sh_q[CRC_W-2:0], 1'b0};
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      crc_q        <= INIT;
      sh_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
    end
  end

  assign din_ready  = (state_q == COMPUTE);
  assign busy       = (state_q == COMPUTE) || (state_q == FLUSH);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign done       = done_q;

endmodule
